fpu_fixed_lat_retire: RTL and testbench

Retire buffer for the fixed-latency, non-stallable FPU conversion units (first client: the integer-to-float converter, latency 2).
- Accepts tagged issues from the FPU dispatch stage and drives the unit's input-valid.
- Carries each destination tag through a delay line matched to the unit latency.
- Captures the unit's result and out-valid into a FIFO, then drains {tag, result} to writeback under a valid/ready handshake.
- Credit logic stops issue so a result never arrives when the FIFO has no room.

---
 rtl/fpu_pkg.sv | 17 +
 rtl/retire_fifo.sv | 73 +++++++
 rtl/fpu_fixed_lat_retire.sv | 134 +++++++++++++
 tb/tb_fpu_fixed_lat_retire.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the retire path.
// Provides default tag/result widths, the destination tag type, the retire
// entry record and the latency of the integer-to-float converter.
package fpu_pkg;

  localparam int unsigned FPU_TAG_W    = 5;
  localparam int unsigned FPU_DATA_W   = 32;
  localparam int unsigned ITOF_LATENCY = 2;

  typedef logic [FPU_TAG_W-1:0] fpu_tag_t;

  typedef struct packed {
    fpu_tag_t                tag;
    logic [FPU_DATA_W-1:0]   data;
  } retire_entry_t;

endpackage

// File: rtl/retire_fifo.sv
// Retire FIFO: DEPTH entries of entry_t, head read combinationally from
// registered storage. Only pointers and count are reset; storage is not.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail (ignored when full, unless popping)
//   pop_i           advance the head (ignored when empty)
//   head_o          entry at the head
//   count_o         current occupancy, 0..DEPTH
//   full_o, empty_o occupancy flags
module retire_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = retire_entry_t,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fpu_fixed_lat_retire.sv
// Retire buffer for fixed-latency, non-stallable FPU units.
// Issues tagged operations into the unit, carries the tag alongside through a
// delay line of the unit's latency, queues {tag, result} and drains it to
// writeback under valid/ready. Credits stop issue before the queue could
// overflow; err flags any disagreement between the unit and the delay line.
// Ports:
//   sys_clk, rst                  clock, asynchronous active-low reset
//   issue_valid/tag/ready         dispatch handshake
//   unit_in_valid                 unit input-valid (= accepted issue)
//   unit_out_valid, unit_y        unit result
//   wb_valid/tag/data/ready       writeback handshake, FIFO head
//   err                           sticky protocol error
module fpu_fixed_lat_retire
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = ITOF_LATENCY,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = FPU_TAG_W,
  parameter int unsigned DATA_W  = FPU_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              issue_ready,
  output logic              unit_in_valid,
  input  logic              unit_out_valid,
  input  logic [DATA_W-1:0] unit_y,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic              err
);

  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned InflW  = $clog2(LATENCY + 1);
  localparam int unsigned SumW   = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned GuardW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic               issue_fire;
  logic               ready_en_q;
  logic [LATENCY-1:0] dl_v_q;
  logic [TAG_W-1:0]   dl_tag_q [LATENCY];
  logic               exit_v;
  logic [InflW-1:0]   inflight;
  logic [SumW-1:0]    credit_used;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  logic               pop, drop, mismatch;
  logic [GuardW-1:0]  guard_q, guard_d;
  logic               guard_done;
  logic               err_q, err_d;
  entry_t             push_entry, head;

  // Delay line and credit
  assign exit_v = dl_v_q[LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) inflight = inflight + InflW'(dl_v_q[k]);
  end

  // A same-cycle pop is deliberately not credited: ready stays off the
  // writeback combinational path.
  assign credit_used   = SumW'(fifo_count) + SumW'(inflight);
  assign issue_ready   = ready_en_q & (credit_used < SumW'(DEPTH));
  assign issue_fire    = issue_valid & issue_ready;
  assign unit_in_valid = issue_fire;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
      dl_v_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      dl_v_q[0]  <= issue_fire;
      for (int k = 1; k < LATENCY; k++) dl_v_q[k] <= dl_v_q[k-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    dl_tag_q[0] <= issue_tag;
    for (int k = 1; k < LATENCY; k++) dl_tag_q[k] <= dl_tag_q[k-1];
  end

  // Retire queue
  assign pop        = ~fifo_empty & wb_ready;
  assign push_entry = '{tag: dl_tag_q[LATENCY-1], data: unit_y};

  retire_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_ni     (rst),
    .push_i     (exit_v),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_tag   = head.tag;
  assign wb_data  = head.data;

  // Error tracking. The unit has no reset, so for LATENCY cycles after
  // release it may still emit valids from before reset; those are ignored.
  assign guard_done = (guard_q == GuardW'(LATENCY));
  assign guard_d    = guard_done ? guard_q : guard_q + GuardW'(1);
  assign mismatch   = guard_done & (unit_out_valid != exit_v);
  assign drop       = exit_v & fifo_full & ~pop;
  assign err_d      = err_q | mismatch | drop;
  assign err        = err_q;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      guard_q <= '0;
      err_q   <= 1'b0;
    end else begin
      guard_q <= guard_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fpu_fixed_lat_retire.sv
module tb_fpu_fixed_lat_retire;

  logic        sys_clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_tag;
  logic        issue_ready;
  logic        unit_in_valid;
  logic        unit_out_valid;
  logic [31:0] unit_y;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        err;

  // Behavioural itof unit, latency 2, no reset; inject forces a spurious valid.
  logic [31:0] x_in;
  logic        inject;
  logic [1:0]  u_v = '0;
  logic [31:0] u_y0, u_y1;

  int n_pass = 0;
  int n_total = 0;

  fpu_fixed_lat_retire dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_tag     (issue_tag),
    .issue_ready   (issue_ready),
    .unit_in_valid (unit_in_valid),
    .unit_out_valid(unit_out_valid),
    .unit_y        (unit_y),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .err           (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] itof(input logic signed [31:0] x);
    logic [63:0] m, rem, half;
    logic [23:0] mant;
    logic        s;
    int          e, sh;
    if (x == 0) return 32'h0;
    s = x[31];
    m = s ? 64'(-longint'(x)) : 64'(longint'(x));
    e = 0;
    for (int i = 0; i < 64; i++) if (m[i]) e = i;
    if (e <= 23) begin
      mant = 24'(m << (23 - e));
    end else begin
      sh   = e - 23;
      mant = 24'(m >> sh);
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) begin
        mant = mant + 24'd1;
        if (mant == 24'd0) begin
          mant = 24'h800000;
          e    = e + 1;
        end
      end
    end
    return {s, 8'(e + 127), mant[22:0]};
  endfunction

  assign unit_out_valid = u_v[1] | inject;
  assign unit_y         = u_y1;

  always @(posedge sys_clk) begin
    u_v  <= {u_v[0], unit_in_valid};
    u_y0 <= itof(x_in);
    u_y1 <= u_y0;
  end

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[8];
  vec_t bp[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic do_reset();
    issue_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk1("rst_ready", issue_ready, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{tag: 5'd1, x: 32'hFFFFFFFF, y: 32'hBF800000};
    vecs[1] = '{tag: 5'd2, x: 32'h00000000, y: 32'h00000000};
    vecs[2] = '{tag: 5'd3, x: 32'h7FFFFFFF, y: 32'h4F000000};
    vecs[3] = '{tag: 5'd4, x: 32'd3,        y: 32'h40400000};
    vecs[4] = '{tag: 5'd5, x: 32'h01000001, y: 32'h4B800000};
    vecs[5] = '{tag: 5'd6, x: 32'd100,      y: 32'h42C80000};
    vecs[6] = '{tag: 5'd7, x: 32'h80000000, y: 32'hCF000000};
    vecs[7] = '{tag: 5'd31, x: 32'd1,       y: 32'h3F800000};
    bp[0] = '{tag: 5'd0, x: 32'd0, y: 32'h00000000};
    bp[1] = '{tag: 5'd1, x: 32'd1, y: 32'h3F800000};
    bp[2] = '{tag: 5'd2, x: 32'd2, y: 32'h40000000};
    bp[3] = '{tag: 5'd3, x: 32'd3, y: 32'h40400000};
    bp[4] = '{tag: 5'd4, x: 32'd4, y: 32'h40800000};

    rst = 1'b0; issue_valid = 1'b0; issue_tag = '0; x_in = '0;
    wb_ready = 1'b0; inject = 1'b0;
    #2;
    chk1("init_ready", issue_ready, 1'b0);
    chk1("init_wb_valid", wb_valid, 1'b0);
    chk1("init_err", err, 1'b0);
    #10 rst = 1'b1;
    step();
    chk1("post_rst_ready", issue_ready, 1'b1);
    repeat (3) step();

    // Single issue: latency to wb_valid is 3 cycles.
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_tag = 5'd3; x_in = 32'd1;
    #1;
    chk1("t1_unit_in_valid", unit_in_valid, 1'b1);
    step(); issue_valid = 1'b0; #1;
    chk1("t1_c1_wb_valid", wb_valid, 1'b0);
    step(); #1;
    chk1("t1_c2_wb_valid", wb_valid, 1'b0);
    step(); #1;
    chk1("t1_c3_wb_valid", wb_valid, 1'b1);
    chk32("t1_tag", 32'(wb_tag), 32'd3);
    chk32("t1_data", wb_data, 32'h3F800000);
    chk1("t1_err", err, 1'b0);
    step(); #1;
    chk1("t1_c4_wb_valid", wb_valid, 1'b0);

    // Back-to-back table, one issue per cycle, results in order 3 cycles later.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        issue_valid = 1'b1; issue_tag = vecs[c].tag; x_in = vecs[c].x;
      end else begin
        issue_valid = 1'b0;
      end
      #1;
      if (c < 8) chk1("t2_ready", issue_ready, 1'b1);
      if (c >= 3) begin
        chk1("t2_wb_valid", wb_valid, 1'b1);
        chk32("t2_tag", 32'(wb_tag), 32'(vecs[c-3].tag));
        chk32("t2_data", wb_data, vecs[c-3].y);
      end
      step();
    end
    chk1("t2_err", err, 1'b0);

    // Backpressure: exactly DEPTH accepted, then drain and resume.
    wb_ready = 1'b0;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 8; c++) begin
        issue_valid = 1'b1; issue_tag = 5'(k); x_in = 32'(k);
        #1;
        chk1("t3_fill_ready", issue_ready, logic'(c < 4));
        if (issue_ready) k++;
        step();
      end
      chk32("t3_accepted", 32'(k), 32'd4);
    end
    wb_ready = 1'b1;
    for (int d = 0; d < 5; d++) begin
      #1;
      chk1("t3_wb_valid", wb_valid, 1'b1);
      chk32("t3_tag", 32'(wb_tag), 32'(bp[d].tag));
      chk32("t3_data", wb_data, bp[d].y);
      if (d == 0) chk1("t3_ready_at_pop", issue_ready, 1'b0);
      if (d == 1) chk1("t3_ready_after_pop", issue_ready, 1'b1);
      step();
      if (d == 1) issue_valid = 1'b0;
    end
    #1;
    chk1("t3_drained", wb_valid, 1'b0);
    step();

    // Simultaneous pop and push at the credit limit.
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      issue_valid = 1'b1; issue_tag = 5'(8 + c); x_in = 32'(8 + c);
      #1;
      chk1("t4_issue_ready", issue_ready, 1'b1);
      step();
    end
    issue_valid = 1'b0;
    #1;
    chk1("t4_c4_ready", issue_ready, 1'b0);
    step(); #1;
    chk1("t4_c5_ready", issue_ready, 1'b0);
    chk32("t4_head8_tag", 32'(wb_tag), 32'd8);
    chk32("t4_head8_data", wb_data, 32'h41000000);
    wb_ready = 1'b1;
    step(); wb_ready = 1'b0; #1;
    chk1("t4_c6_ready", issue_ready, 1'b1);
    chk32("t4_head9_tag", 32'(wb_tag), 32'd9);
    chk32("t4_head9_data", wb_data, 32'h41100000);
    wb_ready = 1'b1;
    step(); #1;
    chk32("t4_head10_tag", 32'(wb_tag), 32'd10);
    chk32("t4_head10_data", wb_data, 32'h41200000);
    step(); #1;
    chk1("t4_last_valid", wb_valid, 1'b1);
    chk32("t4_head11_tag", 32'(wb_tag), 32'd11);
    chk32("t4_head11_data", wb_data, 32'h41300000);
    step(); #1;
    chk1("t4_empty", wb_valid, 1'b0);
    chk1("t4_err", err, 1'b0);

    // Spurious unit_out_valid with an empty delay line.
    step();
    do_reset();
    repeat (5) step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    #1;
    chk1("t5_err_set", err, 1'b1);
    chk1("t5_no_push", wb_valid, 1'b0);
    repeat (3) step();
    #1;
    chk1("t5_err_sticky", err, 1'b1);
    chk1("t5_still_empty", wb_valid, 1'b0);

    // Reset with 2 queued and 2 in flight; stale unit valids after release.
    wb_ready = 1'b0;
    step();
    issue_valid = 1'b1; issue_tag = 5'd20; x_in = 32'd20;
    step();
    issue_tag = 5'd21; x_in = 32'd21;
    step();
    issue_valid = 1'b0;
    step();
    step();
    #1;
    chk32("t6_queued_head", 32'(wb_tag), 32'd20);
    issue_valid = 1'b1; issue_tag = 5'd22; x_in = 32'd22;
    #1;
    chk1("t6_ready22", issue_ready, 1'b1);
    step();
    issue_tag = 5'd23; x_in = 32'd23;
    #1;
    chk1("t6_ready23", issue_ready, 1'b1);
    step();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk1("t6_wb_valid", wb_valid, 1'b0);
      chk1("t6_err", err, 1'b0);
      chk1("t6_ready", issue_ready, 1'b1);
    end
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_tag = 5'd24; x_in = 32'hFFFFFFFB;
    #1;
    chk1("t6_new_fire", unit_in_valid, 1'b1);
    step();
    issue_valid = 1'b0;
    step();
    step(); #1;
    chk1("t6_new_wb_valid", wb_valid, 1'b1);
    chk32("t6_new_tag", 32'(wb_tag), 32'd24);
    chk32("t6_new_data", wb_data, 32'hC0A00000);
    chk1("t6_new_err", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
